// File: rtl/stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/scoreboard unit.
// Register index width, forward-select codes and shadow entry layout.
package stall_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                 v;
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic                 ld;
    } sb_entry_t;

endpackage

// File: rtl/stall_ctrl_sb_match.sv
// Compare one ID source index against one in-flight destination.
// x0 is hard-wired zero, so it never matches.
import stall_ctrl_pkg::*;

module sb_match (
    input  logic                 used,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 ent_v,
    input  logic                 ent_we,
    input  logic [REG_IDX_W-1:0] ent_rd,
    output logic                 hit
);

    // Entry writes rs and the source is really read
    always_comb begin
        hit = used & ent_v & ent_we & (ent_rd == rs) & (rs != '0);
    end

endmodule

// File: rtl/stall_ctrl.sv
// Hazard detection and EX operand forwarding for the 5-stage pipe.
// Shadows rd of the EX/MEM occupants; WB needs no tracking (write-before-read RF).
import stall_ctrl_pkg::*;

module stall_ctrl #(
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 id_we,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic                 id_is_load,
    input  logic                 flush,
    output logic                 stop,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_W-1:0]     stall_cycles
);

    sb_entry_t            ex_q;
    logic                 mem_v;
    logic                 mem_we;
    logic [REG_IDX_W-1:0] mem_rd;

    logic      a_ex, a_mem, b_ex, b_mem;
    logic      ex_load;
    logic [1:0] sel_a, sel_b;
    sb_entry_t id_ent;

    sb_match u_a_ex (
        .used   (id_rs1_used),
        .rs     (id_rs1),
        .ent_v  (ex_q.v),
        .ent_we (ex_q.we),
        .ent_rd (ex_q.rd),
        .hit    (a_ex)
    );

    sb_match u_a_mem (
        .used   (id_rs1_used),
        .rs     (id_rs1),
        .ent_v  (mem_v),
        .ent_we (mem_we),
        .ent_rd (mem_rd),
        .hit    (a_mem)
    );

    sb_match u_b_ex (
        .used   (id_rs2_used),
        .rs     (id_rs2),
        .ent_v  (ex_q.v),
        .ent_we (ex_q.we),
        .ent_rd (ex_q.rd),
        .hit    (b_ex)
    );

    sb_match u_b_mem (
        .used   (id_rs2_used),
        .rs     (id_rs2),
        .ent_v  (mem_v),
        .ent_we (mem_we),
        .ent_rd (mem_rd),
        .hit    (b_mem)
    );

    // Stall request, EX load enable and next forward selects
    always_comb begin
        stop    = 1'b0;
        ex_load = 1'b0;
        sel_a   = FWD_RF;
        sel_b   = FWD_RF;
        id_ent  = '{v: id_valid, we: id_we, rd: id_rd, ld: id_is_load};
        if (FORWARDING != 0) begin
            stop = id_valid & ~flush & ex_q.ld & (a_ex | b_ex);
        end else begin
            stop = id_valid & ~flush & (a_ex | b_ex | a_mem | b_mem);
        end
        ex_load = id_valid & ~flush & ~stop;
        if (FORWARDING != 0) begin
            if (a_ex) begin
                sel_a = FWD_MEM;
            end else if (a_mem) begin
                sel_a = FWD_WB;
            end
            if (b_ex) begin
                sel_b = FWD_MEM;
            end else if (b_mem) begin
                sel_b = FWD_WB;
            end
        end
    end

    // Shadow advance: flush or stall drop a bubble into EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= '0;
            mem_v  <= 1'b0;
            mem_we <= 1'b0;
            mem_rd <= '0;
        end else begin
            ex_q   <= (flush | stop) ? '0 : id_ent;
            mem_v  <= ex_q.v;
            mem_we <= ex_q.we;
            mem_rd <= ex_q.rd;
        end
    end

    // Forward selects follow the instruction entering EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            fwd_a <= ex_load ? sel_a : FWD_RF;
            fwd_b <= ex_load ? sel_b : FWD_RF;
        end
    end

    // Free-running count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stop) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: one bypassed and one non-bypassed instance.
// Directed pipeline scenarios then random traffic against a history model.
module tb_stall_ctrl;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic       we;
        logic [4:0] rd;
        logic       ld;
        logic       fl;
    } id_t;

    typedef struct packed {
        logic       v;
        logic       we;
        logic [4:0] rd;
        logic       ld;
    } hist_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    id_t        in_q [2];
    logic       stop_o [2];
    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic [3:0] cnt [2];

    // model: hist[k][0] = youngest issued (in EX), hist[k][1] = one older
    hist_t      hist [2][2];
    logic [1:0] fm_a [2];
    logic [1:0] fm_b [2];
    logic [3:0] cm [2];

    int checks = 0;
    int passes = 0;
    int st;

    always #5 clk = ~clk;

    stall_ctrl #(.FORWARDING(1), .CNT_W(4)) u_fwd (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (in_q[0].v),
        .id_rs1       (in_q[0].rs1),
        .id_rs2       (in_q[0].rs2),
        .id_rs1_used  (in_q[0].u1),
        .id_rs2_used  (in_q[0].u2),
        .id_we        (in_q[0].we),
        .id_rd        (in_q[0].rd),
        .id_is_load   (in_q[0].ld),
        .flush        (in_q[0].fl),
        .stop         (stop_o[0]),
        .fwd_a        (fa[0]),
        .fwd_b        (fb[0]),
        .stall_cycles (cnt[0])
    );

    stall_ctrl #(.FORWARDING(0), .CNT_W(4)) u_nofwd (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (in_q[1].v),
        .id_rs1       (in_q[1].rs1),
        .id_rs2       (in_q[1].rs2),
        .id_rs1_used  (in_q[1].u1),
        .id_rs2_used  (in_q[1].u2),
        .id_we        (in_q[1].we),
        .id_rd        (in_q[1].rd),
        .id_is_load   (in_q[1].ld),
        .flush        (in_q[1].fl),
        .stop         (stop_o[1]),
        .fwd_a        (fa[1]),
        .fwd_b        (fb[1]),
        .stall_cycles (cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic id_t mk(input logic v, input int rs1, input logic u1,
                               input int rs2, input logic u2, input logic we,
                               input int rd, input logic ld, input logic fl);
        id_t r;
        r.v   = v;
        r.rs1 = 5'(rs1);
        r.u1  = u1;
        r.rs2 = 5'(rs2);
        r.u2  = u2;
        r.we  = we;
        r.rd  = 5'(rd);
        r.ld  = ld;
        r.fl  = fl;
        return r;
    endfunction

    // does an older instruction deliver register r that ID actually reads
    function automatic bit prod(input hist_t h, input logic [4:0] r,
                                input logic used);
        return used && h.v && h.we && h.rd == r && r != 5'd0;
    endfunction

    // bypassed: only a load one ahead stalls; no bypass: anything within two
    function automatic bit m_stop(input int k);
        id_t i;
        bit  hz;
        i = in_q[k];
        if (k == 0)
            hz = hist[0][0].ld &&
                 (prod(hist[0][0], i.rs1, i.u1) || prod(hist[0][0], i.rs2, i.u2));
        else
            hz = prod(hist[1][0], i.rs1, i.u1) || prod(hist[1][0], i.rs2, i.u2) ||
                 prod(hist[1][1], i.rs1, i.u1) || prod(hist[1][1], i.rs2, i.u2);
        return i.v && !i.fl && hz;
    endfunction

    function automatic logic [1:0] m_sel(input int k, input logic [4:0] r,
                                         input logic used);
        if (k != 0) return 2'b00;
        if (prod(hist[k][0], r, used)) return 2'b01;
        if (prod(hist[k][1], r, used)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            hist[k][0] = '0;
            hist[k][1] = '0;
            fm_a[k]    = 2'b00;
            fm_b[k]    = 2'b00;
            cm[k]      = 4'd0;
        end
    endtask

    // one clock: check mid-cycle, then advance the model at the edge
    task automatic tick();
        bit    s [2];
        id_t   i;
        hist_t n;
        for (int k = 0; k < 2; k++) s[k] = m_stop(k);
        #3;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stop%0d", k), 32'(stop_o[k]), 32'(s[k]));
            chk($sformatf("fwd_a%0d", k), 32'(fa[k]), 32'(fm_a[k]));
            chk($sformatf("fwd_b%0d", k), 32'(fb[k]), 32'(fm_b[k]));
            chk($sformatf("cnt%0d", k), 32'(cnt[k]), 32'(cm[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            i = in_q[k];
            if (s[k]) cm[k] = cm[k] + 4'd1;
            if (i.v && !i.fl && !s[k]) begin
                fm_a[k] = m_sel(k, i.rs1, i.u1);
                fm_b[k] = m_sel(k, i.rs2, i.u2);
            end else begin
                fm_a[k] = 2'b00;
                fm_b[k] = 2'b00;
            end
            n = '{v: i.v, we: i.we, rd: i.rd, ld: i.ld};
            if (i.fl || s[k]) n = '0;
            hist[k][1] = hist[k][0];
            hist[k][0] = n;
        end
        #1;
    endtask

    // hold an instruction in ID until it is accepted; count stall cycles
    task automatic issue(input int k, input id_t ins, output int stalls);
        bit s;
        stalls = 0;
        in_q[k] = ins;
        for (int n = 0; n < 8; n++) begin
            s = m_stop(k);
            tick();
            if (!s) break;
            stalls++;
        end
        in_q[k] = '0;
    endtask

    task automatic do_reset();
        in_q[0] = '0;
        in_q[1] = '0;
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_stop", 32'(stop_o[k]), 32'd0);
            chk("rst_fa", 32'(fa[k]), 32'd0);
            chk("rst_fb", 32'(fb[k]), 32'd0);
            chk("rst_cnt", 32'(cnt[k]), 32'd0);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_q[0] = '0;
        in_q[1] = '0;
        m_reset();
        #1;
        do_reset();

        // load-use with bypass: one stall, consumer takes WB value
        issue(0, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), st);
        issue(0, mk(1, 5, 1, 1, 1, 1, 6, 0, 0), st);
        chk("lu_stalls", 32'(st), 32'd1);
        chk("lu_fwd_a", 32'(fa[0]), 32'b10);
        chk("lu_cnt", 32'(cnt[0]), 32'd1);

        // ALU-ALU with bypass: no stall, both operands from MEM
        issue(0, mk(1, 1, 1, 2, 1, 1, 5, 0, 0), st);
        issue(0, mk(1, 5, 1, 5, 1, 1, 7, 0, 0), st);
        chk("alu_stalls", 32'(st), 32'd0);
        chk("alu_fwd_a", 32'(fa[0]), 32'b01);
        chk("alu_fwd_b", 32'(fb[0]), 32'b01);

        // no bypass: producer adjacent -> 2 stalls, one gap -> 1 stall
        issue(1, mk(1, 1, 1, 2, 1, 1, 5, 0, 0), st);
        issue(1, mk(1, 2, 1, 5, 1, 1, 8, 0, 0), st);
        chk("nf_adj", 32'(st), 32'd2);
        chk("nf_fwd_b", 32'(fb[1]), 32'b00);
        issue(1, mk(1, 1, 1, 2, 1, 1, 5, 0, 0), st);
        issue(1, mk(1, 1, 1, 1, 1, 1, 9, 0, 0), st);
        issue(1, mk(1, 2, 1, 5, 1, 1, 8, 0, 0), st);
        chk("nf_gap", 32'(st), 32'd1);

        // flush beats a load-use hazard and kills EX
        issue(0, mk(1, 0, 0, 0, 0, 1, 3, 1, 0), st);
        in_q[0] = mk(1, 3, 1, 0, 0, 1, 4, 0, 1);
        #2;
        chk("fl_stop", 32'(stop_o[0]), 32'd0);
        tick();
        in_q[0] = mk(1, 3, 1, 0, 0, 1, 4, 0, 0);
        #2;
        chk("fl_after", 32'(stop_o[0]), 32'd0);
        tick();
        in_q[0] = '0;

        // x0 never stalls either instance
        issue(0, mk(1, 0, 0, 0, 0, 1, 0, 1, 0), st);
        issue(0, mk(1, 0, 1, 0, 1, 1, 6, 0, 0), st);
        chk("x0_fwd", 32'(st), 32'd0);
        issue(1, mk(1, 0, 0, 0, 0, 1, 0, 1, 0), st);
        issue(1, mk(1, 0, 1, 0, 1, 1, 6, 0, 0), st);
        chk("x0_nofwd", 32'(st), 32'd0);

        // counter wrap at 4 bits
        do_reset();
        for (int n = 0; n < 15; n++) begin
            issue(0, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), st);
            issue(0, mk(1, 5, 1, 1, 1, 1, 6, 0, 0), st);
        end
        chk("cnt_15", 32'(cnt[0]), 32'd15);
        issue(0, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), st);
        issue(0, mk(1, 5, 1, 1, 1, 1, 6, 0, 0), st);
        chk("cnt_wrap", 32'(cnt[0]), 32'd0);

        // random traffic on small register range to hit hazards often
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++)
                in_q[k] = mk(1'($urandom_range(0, 3) != 0),
                             int'($urandom_range(0, 3)), 1'($urandom),
                             int'($urandom_range(0, 3)), 1'($urandom),
                             1'($urandom), int'($urandom_range(0, 3)),
                             1'($urandom), 1'($urandom_range(0, 9) == 0));
            tick();
        end

        // asynchronous reset in the middle of a stall
        in_q[0] = '0;
        in_q[1] = '0;
        tick();
        issue(0, mk(1, 0, 0, 0, 0, 1, 4, 1, 0), st);
        in_q[0] = mk(1, 4, 1, 0, 0, 1, 7, 0, 0);
        #2;
        chk("mid_stop_pre", 32'(stop_o[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_stop", 32'(stop_o[0]), 32'd0);
        chk("mid_fa", 32'(fa[0]), 32'd0);
        chk("mid_fb", 32'(fb[0]), 32'd0);
        chk("mid_cnt", 32'(cnt[0]), 32'd0);
        in_q[0] = '0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Hazard-detection and scoreboard unit for the 5-stage pipeline. Produces the `stop` stall request consumed by the pipeline valid-tracking logic, and the EX-stage operand forwarding selects. It keeps a private shadow of the destination registers in flight in EX/MEM/WB. The shadow advances under the same flush/stall rules as the pipeline valid bits, so it stays aligned with them.

## Interface
Parameters:
- `FORWARDING`, default 1: 1 = MEM/WB bypass exists, stall only on load-use; 0 = no bypass, stall on any RAW against EX or MEM.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single pipeline clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs1`, `id_rs2`  in  5  ID source register indices.
- `id_rs1_used`, `id_rs2_used`  in  1  source actually read.
- `id_we`  in  1  ID instruction writes the register file.
- `id_rd`  in  5  ID destination index.
- `id_is_load`  in  1  ID instruction is a load.
- `flush`  in  1  taken branch/redirect resolved this cycle; kills IF/ID/EX contents.
- `stop`  out  1  stall IF/ID, insert bubble into EX (combinational).
- `fwd_a`, `fwd_b`  out  2  operand source for instruction now in EX: 00 regfile, 01 MEM result, 10 WB result (registered).
- `stall_cycles`  out  CNT_W  count of cycles with `stop`=1.

## Operation
- Shadow entries EX, MEM, WB each hold {v, we, rd, ld}. Entry "writes r" means v & we & rd==r & r!=0.
- Source match: `id_rsN_used` and an entry writes `id_rsN`.
- FORWARDING=1: `stop` = id_valid & !flush & (rs1 or rs2 matches EX entry with ld=1).
- FORWARDING=0: `stop` = id_valid & !flush & (rs1 or rs2 matches EX entry or MEM entry).
- The register file is write-before-read, so a WB match is never a hazard.
- `flush` forces `stop`=0.
- Shadow update each rising edge:
  - if flush: EX ← invalid.
  - else if stop: EX ← invalid (bubble).
  - else EX ← {id_valid, id_we, id_rd, id_is_load}.
  - Always: MEM ← EX, WB ← MEM.
- Forward selects are loaded only when EX loads a new instruction; otherwise they are cleared to 00.
  - Per source: 01 if the current EX entry writes rsN (producer will be in MEM).
  - Else 10 if the current MEM entry writes rsN (producer will be in WB).
  - Else 00.
  - With FORWARDING=0, the selects are always 00.
- `stall_cycles` increments on every cycle with `stop`=1 and wraps modulo 2^CNT_W.

## Timing
- Reset values: all shadow entries invalid, `fwd_a`=`fwd_b`=00, `stall_cycles`=0, `stop`=0 (follows from invalid entries).
- `stop` is same-cycle combinational from ID inputs and the shadow.
- Load-use with FORWARDING=1: exactly 1 stall cycle. On the next cycle the load is in MEM and the consumer's select becomes 10 when it enters EX.
- FORWARDING=0: 2 stall cycles when the producer is in EX, 1 when it is in MEM.
- Simultaneous flush and hazard: flush wins, `stop`=0, EX ← invalid.
- rd=0 never causes a stall or a forward.
- Reset mid-stall: outputs return to reset values immediately (asynchronous reset); the counter clears.

## Structure
- A shared pipeline package holds:
  - `REG_IDX_W`=5
  - `FWD_RF`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10
  - a packed struct for the shadow entry {v, we, rd, ld}
- One sub-module, `sb_match`: a combinational compare of a source index against one entry, instantiated per source × entry.
- The counter is inline.

## Test plan
- Reset: assert `rst` mid-run → `stop`=0, `fwd_a`=`fwd_b`=00, `stall_cycles`=0, all entries invalid.
- Load-use, FORWARDING=1: cycle N ID `lw x5`; cycle N+1 ID `add x6,x5,x1` → `stop`=1 for exactly one cycle. When the add reaches EX, `fwd_a`=10 and `stall_cycles`=1.
- ALU-ALU, FORWARDING=1: `add x5`, then `sub x7,x5,x5` → no stall; `fwd_a`=`fwd_b`=01 when the sub is in EX.
- No forwarding (FORWARDING=0): `add x5`, then `or x8,x2,x5` → `stop`=1 for 2 cycles, then `fwd_b`=00. With one independent instruction between them → 1 stall cycle.
- Flush priority: load x3 in EX, ID uses x3, `flush`=1 same cycle → `stop`=0; next cycle EX entry invalid and no stall.
- x0 and wrap: load writing x0 followed by a consumer of x0 → no stall. Counter preloaded via stall sequences to 2^CNT_W−1 (CNT_W=4 build: 15), then one more stall cycle → 0.
